// File: rtl/i2s_rx_dsp_channel.sv
// i2s_rx_dsp_channel
// Receive side of the I2S DSP (frame-sync pulse) mode. One or two serial
// lines are deserialised into 32-bit words. Completed words go into a
// 2-entry queue that feeds the RX FIFO through a valid/ready handshake.
module i2s_rx_dsp_channel #(
    parameter int OFFSET_W = 9
) (
    input  logic                sck_i,
    input  logic                rst_i,
    input  logic                i2s_ws_i,
    input  logic                i2s_sd0_i,
    input  logic                i2s_sd1_i,
    output logic [31:0]         fifo_data_o,
    output logic                fifo_data_valid_o,
    input  logic                fifo_data_ready_i,
    output logic                fifo_err_o,
    input  logic                cfg_en_i,
    input  logic                cfg_2ch_i,
    input  logic [4:0]          cfg_num_bits_i,
    input  logic [3:0]          cfg_num_word_i,
    input  logic                cfg_lsb_first_i,
    input  logic [OFFSET_W-1:0] cfg_dsp_offset_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_WS,
        ST_OFFSET,
        ST_RUN
    } state_t;

    state_t              state_reg, state_next;
    logic [OFFSET_W-1:0] offset_cnt_reg;
    logic [OFFSET_W-1:0] offset_cnt_inc;
    logic                offset_done;
    logic [4:0]          bit_cnt_reg;
    logic [4:0]          bit_idx;
    logic [3:0]          word_cnt_reg;
    logic                word_done;
    logic                last_word;
    logic [1:0]          sd_bits;
    logic [31:0]         word_next [2];

    logic [31:0]         q_reg [2];
    logic [1:0]          q_cnt_reg;
    logic [1:0]          cnt_after_pop;
    logic                pop;
    logic                err_reg;

    assign sd_bits = {i2s_sd1_i, i2s_sd0_i};

    // State register
    always_ff @(posedge sck_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; disabling the channel always wins
    always_comb begin
        state_next = state_reg;
        if (!cfg_en_i) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:    state_next = ST_WAIT_WS;
                ST_WAIT_WS: begin
                    if (i2s_ws_i) begin
                        state_next = (cfg_dsp_offset_i == '0) ? ST_RUN : ST_OFFSET;
                    end
                end
                ST_OFFSET:  begin
                    if (offset_done) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN:     begin
                    if (word_done && last_word) begin
                        state_next = ST_WAIT_WS;
                    end
                end
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // FSM-derived strobes: offset expiry, bit placement and word completion
    always_comb begin
        offset_cnt_inc = offset_cnt_reg + OFFSET_W'(1);
        offset_done    = (offset_cnt_inc == cfg_dsp_offset_i);
        bit_idx        = cfg_lsb_first_i ? bit_cnt_reg : (cfg_num_bits_i - bit_cnt_reg);
        word_done      = cfg_en_i && (state_reg == ST_RUN) && (bit_cnt_reg == cfg_num_bits_i);
        last_word      = (word_cnt_reg == cfg_num_word_i);
    end

    // Offset, bit and word counters
    always_ff @(posedge sck_i) begin
        if (rst_i || !cfg_en_i) begin
            offset_cnt_reg <= '0;
            bit_cnt_reg    <= '0;
            word_cnt_reg   <= '0;
        end else begin
            offset_cnt_reg <= (state_reg == ST_OFFSET && !offset_done) ? offset_cnt_inc : '0;
            if (state_reg == ST_RUN) begin
                if (word_done) begin
                    bit_cnt_reg  <= '0;
                    word_cnt_reg <= last_word ? 4'd0 : word_cnt_reg + 4'd1;
                end else begin
                    bit_cnt_reg  <= bit_cnt_reg + 5'd1;
                end
            end else begin
                bit_cnt_reg  <= '0;
                word_cnt_reg <= '0;
            end
        end
    end

    // Per-channel assembly registers; the current bit is merged combinationally
    // so a completed word can be pushed on the same edge as its last bit.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic [31:0] sr_reg;

            assign word_next[gi] = sr_reg | (32'(sd_bits[gi]) << bit_idx);

            // Accumulate bits during RUN, start each word from zero
            always_ff @(posedge sck_i) begin
                if (rst_i || !cfg_en_i || state_reg != ST_RUN || word_done) begin
                    sr_reg <= '0;
                end else begin
                    sr_reg <= word_next[gi];
                end
            end
        end
    endgenerate

    assign pop           = (q_cnt_reg != 2'd0) && fifo_data_ready_i;
    assign cnt_after_pop = q_cnt_reg - {1'b0, pop};

    // Output queue: head feeds the FIFO, a completion is only accepted into
    // an empty queue (after this cycle's pop) so ch0/ch1 stay paired.
    always_ff @(posedge sck_i) begin
        if (rst_i || !cfg_en_i) begin
            q_reg[0]  <= '0;
            q_reg[1]  <= '0;
            q_cnt_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            if (word_done && cnt_after_pop == 2'd0) begin
                q_reg[0]  <= word_next[0];
                q_reg[1]  <= cfg_2ch_i ? word_next[1] : 32'd0;
                q_cnt_reg <= cfg_2ch_i ? 2'd2 : 2'd1;
            end else begin
                if (word_done) begin
                    err_reg <= 1'b1;
                end
                if (pop) begin
                    q_reg[0]  <= q_reg[1];
                    q_reg[1]  <= '0;
                    q_cnt_reg <= cnt_after_pop;
                end
            end
        end
    end

    assign fifo_data_o       = q_reg[0];
    assign fifo_data_valid_o = (q_cnt_reg != 2'd0);
    assign fifo_err_o        = err_reg;

endmodule

// File: tb/tb_i2s_rx_dsp_channel.sv
// Self-checking bench for i2s_rx_dsp_channel: directed and randomized frames
// compared against an arithmetic model of word values and pop cycles.
module tb_i2s_rx_dsp_channel;

    localparam int OFFSET_W = 9;

    logic                sck_i = 1'b0;
    logic                rst_i;
    logic                i2s_ws_i;
    logic                i2s_sd0_i;
    logic                i2s_sd1_i;
    logic [31:0]         fifo_data_o;
    logic                fifo_data_valid_o;
    logic                fifo_data_ready_i;
    logic                fifo_err_o;
    logic                cfg_en_i;
    logic                cfg_2ch_i;
    logic [4:0]          cfg_num_bits_i;
    logic [3:0]          cfg_num_word_i;
    logic                cfg_lsb_first_i;
    logic [OFFSET_W-1:0] cfg_dsp_offset_i;

    i2s_rx_dsp_channel #(.OFFSET_W(OFFSET_W)) dut (
        .sck_i             (sck_i),
        .rst_i             (rst_i),
        .i2s_ws_i          (i2s_ws_i),
        .i2s_sd0_i         (i2s_sd0_i),
        .i2s_sd1_i         (i2s_sd1_i),
        .fifo_data_o       (fifo_data_o),
        .fifo_data_valid_o (fifo_data_valid_o),
        .fifo_data_ready_i (fifo_data_ready_i),
        .fifo_err_o        (fifo_err_o),
        .cfg_en_i          (cfg_en_i),
        .cfg_2ch_i         (cfg_2ch_i),
        .cfg_num_bits_i    (cfg_num_bits_i),
        .cfg_num_word_i    (cfg_num_word_i),
        .cfg_lsb_first_i   (cfg_lsb_first_i),
        .cfg_dsp_offset_i  (cfg_dsp_offset_i)
    );

    always #5 sck_i = ~sck_i;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;      // index of the most recent rising edge
    logic [31:0] got_d[$];
    int          got_t[$];
    logic [31:0] exp_d[$];
    int          exp_t[$];
    int          err_cnt = 0;
    int          err_cyc = 0;
    logic [31:0] w0 [16];
    logic [31:0] w1 [16];

    always @(posedge sck_i) cyc <= cyc + 1;

    // Record every handshake (with the edge that pops it) and every error pulse
    always @(negedge sck_i) begin
        #1;
        if (fifo_data_valid_o && fifo_data_ready_i) begin
            got_d.push_back(fifo_data_o);
            got_t.push_back(int'(cyc) + 1);
        end
        if (fifo_err_o) begin
            err_cnt++;
            err_cyc = int'(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic configure(input int two, input int nb, input int nw, input int lsb, input int off);
        cfg_en_i = 1'b0;
        @(negedge sck_i);
        @(negedge sck_i);
        cfg_2ch_i        = 1'(two);
        cfg_num_bits_i   = 5'(nb);
        cfg_num_word_i   = 4'(nw);
        cfg_lsb_first_i  = 1'(lsb);
        cfg_dsp_offset_i = OFFSET_W'(off);
        cfg_en_i = 1'b1;
        @(negedge sck_i);
        @(negedge sck_i);
        got_d.delete(); got_t.delete(); exp_d.delete(); exp_t.delete();
        err_cnt = 0;
    endtask

    // Drive one frame from w0/w1; abort_at >= 0 drops cfg_en_i instead of that bit.
    task automatic send_frame(input int abort_at, output int t);
        int nb, nw, off, n, last, bi;
        logic [31:0] mask;
        nb   = int'(cfg_num_bits_i);
        nw   = int'(cfg_num_word_i);
        off  = int'(cfg_dsp_offset_i);
        mask = (nb == 31) ? 32'hFFFF_FFFF : ((32'd1 << (nb + 1)) - 32'd1);
        i2s_ws_i  = 1'b1;
        i2s_sd0_i = 1'($urandom);
        i2s_sd1_i = 1'($urandom);
        t = int'(cyc) + 1;
        @(negedge sck_i);
        for (int i = 0; i < off; i++) begin
            i2s_ws_i  = 1'($urandom);
            i2s_sd0_i = 1'($urandom);
            i2s_sd1_i = 1'($urandom);
            @(negedge sck_i);
        end
        n = 0;
        for (int w = 0; w <= nw; w++) begin
            for (int j = 0; j <= nb; j++) begin
                if (n == abort_at) begin
                    cfg_en_i = 1'b0;
                    i2s_ws_i = 1'b0;
                    @(negedge sck_i);
                    return;
                end
                bi = cfg_lsb_first_i ? j : nb - j;
                i2s_ws_i  = 1'($urandom);
                i2s_sd0_i = w0[w][bi];
                i2s_sd1_i = w1[w][bi];
                @(negedge sck_i);
                n++;
            end
        end
        i2s_ws_i = 1'b0;
        for (int w = 0; w <= nw; w++) begin
            last = t + off + (w + 1) * (nb + 1);
            exp_d.push_back(w0[w] & mask);
            exp_t.push_back(last + 1);
            if (cfg_2ch_i) begin
                exp_d.push_back(w1[w] & mask);
                exp_t.push_back(last + 2);
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && got_d.size() < exp_d.size(); i++) @(negedge sck_i);
        repeat (4) @(negedge sck_i);
        check($sformatf("%s count", tag), 32'(got_d.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            check($sformatf("%s w%0d data", tag, i), got_d[i], exp_d[i]);
            check($sformatf("%s w%0d cycle", tag, i), 32'(got_t[i]), 32'(exp_t[i]));
        end
        check($sformatf("%s err", tag), 32'(err_cnt), 32'd0);
        got_d.delete(); got_t.delete(); exp_d.delete(); exp_t.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int two, nb;
        rst_i = 1'b1;
        i2s_ws_i = 1'b0; i2s_sd0_i = 1'b0; i2s_sd1_i = 1'b0;
        fifo_data_ready_i = 1'b1;
        cfg_en_i = 1'b0; cfg_2ch_i = 1'b0; cfg_num_bits_i = '0;
        cfg_num_word_i = '0; cfg_lsb_first_i = 1'b0; cfg_dsp_offset_i = '0;
        for (int i = 0; i < 16; i++) begin w0[i] = '0; w1[i] = '0; end

        // Reset
        repeat (2) @(negedge sck_i);
        check("reset data", fifo_data_o, 32'd0);
        check("reset valid", 32'(fifo_data_valid_o), 32'd0);
        check("reset err", 32'(fifo_err_o), 32'd0);
        rst_i = 1'b0;
        configure(0, 15, 0, 0, 0);
        repeat (10) @(negedge sck_i);
        check("no ws count", 32'(got_d.size()), 32'd0);
        check("no ws valid", 32'(fifo_data_valid_o), 32'd0);

        // Basic capture, MSB-first
        w0[0] = 32'h0000_A5C3; w1[0] = $urandom;
        send_frame(-1, t);
        drain("basic");

        // Offset 3, LSB-first
        configure(0, 7, 0, 1, 3);
        w0[0] = 32'h0000_0081; w1[0] = $urandom;
        send_frame(-1, t);
        drain("offset_lsb");

        // Two channels, two words, followed back-to-back by a random frame
        configure(1, 31, 1, 0, 0);
        w0[0] = 32'h1234_5678; w0[1] = 32'h0000_0000;
        w1[0] = 32'hDEAD_BEEF; w1[1] = 32'hFFFF_FFFF;
        send_frame(-1, t);
        for (int i = 0; i < 2; i++) begin w0[i] = $urandom; w1[i] = $urandom; end
        send_frame(-1, t);
        drain("two_ch");

        // Minimum overflow-free word lengths
        configure(0, 0, 7, 0, 0);
        for (int i = 0; i < 8; i++) begin w0[i] = $urandom; w1[i] = $urandom; end
        send_frame(-1, t);
        drain("min_1ch");
        configure(1, 1, 7, 1, 0);
        for (int i = 0; i < 8; i++) begin w0[i] = $urandom; w1[i] = $urandom; end
        send_frame(-1, t);
        drain("min_2ch");

        // Randomized configurations, two back-to-back frames each
        for (int it = 0; it < 8; it++) begin
            two = int'($urandom_range(0, 1));
            nb  = two ? int'($urandom_range(1, 31)) : int'($urandom_range(0, 31));
            configure(two, nb, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                      (it == 3) ? 260 : int'($urandom_range(0, 6)));
            for (int f = 0; f < 2; f++) begin
                for (int i = 0; i < 16; i++) begin w0[i] = $urandom; w1[i] = $urandom; end
                send_frame(-1, t);
            end
            drain($sformatf("rand%0d", it));
        end

        // Overflow: second word dropped, first held, one error pulse
        configure(0, 3, 1, 0, 0);
        fifo_data_ready_i = 1'b0;
        w0[0] = $urandom; w0[1] = $urandom;
        send_frame(-1, t);
        exp_d.delete(); exp_t.delete();
        repeat (3) @(negedge sck_i);
        check("ovf err count", 32'(err_cnt), 32'd1);
        check("ovf err cycle", 32'(err_cyc), 32'(t + 8));
        check("ovf valid held", 32'(fifo_data_valid_o), 32'd1);
        check("ovf data held", fifo_data_o, w0[0] & 32'h0000_000F);
        fifo_data_ready_i = 1'b1;
        repeat (5) @(negedge sck_i);
        check("ovf delivered count", 32'(got_d.size()), 32'd1);
        if (got_d.size() > 0) check("ovf delivered data", got_d[0], w0[0] & 32'h0000_000F);
        check("ovf err final", 32'(err_cnt), 32'd1);

        // Disable at bit 5 of the second word with the first word queued
        configure(0, 15, 1, 0, 0);
        fifo_data_ready_i = 1'b0;
        w0[0] = $urandom; w0[1] = $urandom;
        send_frame(21, t);
        check("dis valid", 32'(fifo_data_valid_o), 32'd0);
        fifo_data_ready_i = 1'b1;
        repeat (5) @(negedge sck_i);
        check("dis emitted", 32'(got_d.size()), 32'd0);
        check("dis err", 32'(err_cnt), 32'd0);
        configure(0, 15, 1, 0, 0);
        w0[0] = $urandom; w0[1] = $urandom;
        send_frame(-1, t);
        drain("reenable");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_rx_dsp_channel.md
# i2s_rx_dsp_channel

Receive-side DSP-mode (frame-sync pulse) channel for the uDMA I2S peripheral. It deserialises one or two serial data lines into 32-bit words and hands them to the RX FIFO over a valid/ready handshake. It supports a programmable start offset after the frame sync, a programmable word length, a programmable words-per-frame count, and MSB- or LSB-first ordering. It sits between the I2S pads / clock-gen and the RX uDMA FIFO, mirroring the TX DSP channel.

## Interface
- OFFSET_W, 9: width of the frame-sync-to-first-bit offset counter and config field.
- sck_i  in  1  serial bit clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- i2s_ws_i  in  1  DSP frame-sync pulse, sampled on sck_i.
- i2s_sd0_i  in  1  serial data, channel 0.
- i2s_sd1_i  in  1  serial data, channel 1 (used only when cfg_2ch_i=1).
- fifo_data_o  out  32  received word, zero-extended above bit cfg_num_bits_i.
- fifo_data_valid_o  out  1  fifo_data_o holds a valid word.
- fifo_data_ready_i  in  1  FIFO accepts the word this cycle.
- fifo_err_o  out  1  one-cycle pulse when completed words are dropped (overflow).
- cfg_en_i  in  1  channel enable.
- cfg_2ch_i  in  1  capture sd1 in parallel with sd0.
- cfg_num_bits_i  in  5  bits per word minus 1 (0..31).
- cfg_num_word_i  in  4  words per frame minus 1.
- cfg_lsb_first_i  in  1  1 = LSB arrives first.
- cfg_dsp_offset_i  in  OFFSET_W  number of sck cycles between frame sync and the first data bit, beyond the default.

## Operation
- States:
  - IDLE: counters, shift registers and the output queue are cleared. cfg_en_i=1 -> WAIT_WS.
  - WAIT_WS: on i2s_ws_i=1, go to RUN if cfg_dsp_offset_i==0, else go to OFFSET.
  - OFFSET: the offset counter counts from 1 to cfg_dsp_offset_i, then -> RUN.
  - RUN: one bit is sampled per cycle.
- In any state, cfg_en_i=0 -> IDLE on the next edge. The partial word and the queue are discarded and valid drops.
- Bit placement: bit counter k = 0..cfg_num_bits_i.
  - MSB-first: the sampled bit goes to index cfg_num_bits_i-k.
  - LSB-first: the sampled bit goes to index k.
  - Bits above cfg_num_bits_i are always 0.
- Word completion (k==cfg_num_bits_i):
  - The ch0 word, then the ch1 word (if cfg_2ch_i), are pushed into a 2-entry output queue.
  - k resets to 0 and the word counter increments.
  - If the word counter was already cfg_num_word_i, it clears and the state goes to WAIT_WS; otherwise RUN continues with the next word on the next cycle.
- i2s_ws_i is ignored in OFFSET and RUN.
- Output queue:
  - Head drives fifo_data_o. A pop happens when valid && ready. Order is always ch0 then ch1.
  - fifo_data_o is stable while valid && !ready.
  - Overflow: if any entry remains after this cycle's pop when a new completion arrives, the new word(s) are dropped, queue contents are kept, and fifo_err_o pulses for 1 cycle.
  - A completion in the same cycle as the pop of the last entry is accepted.
- Config changes are legal only while cfg_en_i=0; other changes are undefined.

## Timing
- Reset values: state IDLE, fifo_data_o=0, fifo_data_valid_o=0, fifo_err_o=0, all counters 0.
- cfg_en_i rising at edge e -> WAIT_WS from e+1. The frame sync is sampled from then on.
- Frame sync sampled high at cycle t:
  - First data bit is sampled at t+1+cfg_dsp_offset_i.
  - Last bit of word 0 is sampled at t+1+offset+cfg_num_bits_i.
  - fifo_data_valid_o is high on the next cycle (1-cycle latency from the last bit).
- 2-channel mode: ch1 is presented the cycle after ch0 is popped (with ready held high, back-to-back).
- Minimum overflow-free word length:
  - 1 channel: 1 bit with ready always high.
  - 2 channels: 2 bits with ready always high.
- A new frame sync is accepted in the cycle immediately after the last word's final bit (WAIT_WS entered that edge).

## Test plan
- Reset: rst_i=1 for 2 cycles -> all outputs 0; cfg_en_i=1 with no ws -> valid stays 0.
- Basic capture: 1 channel, num_bits=15, MSB-first, offset=0, num_word=0, ready=1; ws at t; sd0 drives 0xA5C3 MSB-first from t+1 -> fifo_data_o=0x0000A5C3 valid at t+17 for 1 cycle.
- Offset and LSB-first: num_bits=7, offset=3, lsb_first=1; ws at t; sd0 drives 0x81 LSB-first from t+4 -> word 0x00000081 valid at t+12; bits during t+1..t+3 are ignored.
- Two channels and two words per frame: cfg_2ch=1, num_bits=31, num_word=1.
  - sd0 sends 0x12345678 then 0x0; sd1 sends 0xDEADBEEF then 0xFFFFFFFF.
  - Required output order: 0x12345678, 0xDEADBEEF, 0x0, 0xFFFFFFFF.
  - After the frame, the block returns to WAIT_WS.
- Overflow: ready=0, num_bits=3, 1 channel, two words -> first word held, fifo_err_o pulses 1 cycle at the second completion. Then ready=1 -> only the first word is delivered.
- Disable mid-word: cfg_en_i=0 at bit 5 of a 16-bit word with a queued word and ready=0 -> valid=0 on the next cycle and nothing is emitted. Re-enable -> the next ws starts a clean word.
